// File: rtl/ddr3_master_rd_if.sv
// ddr3_master_rd_if
//   Byte-stream link from ddr3_master_rd to the UDP transmitter.
//   master modport : ddr3_master_rd (drives the bytes and framing flags)
//   slave modport  : UDP transmitter (drives i_udp_ready)
//   Signals:
//     o_udp_data      byte to transmit
//     o_udp_de        byte valid
//     i_udp_ready     sink accepts the byte when o_udp_de && i_udp_ready
//     o_udp_sof/eof   first / last byte of the packet, qualified by o_udp_de
//     o_udp_frame_end asserted with o_udp_eof on the last packet of a frame
//     o_udp_len       packet byte length, valid from the request until the next one
interface ddr3_master_rd_if;
    logic [7:0]  o_udp_data;
    logic        o_udp_de;
    logic        i_udp_ready;
    logic        o_udp_sof;
    logic        o_udp_eof;
    logic        o_udp_frame_end;
    logic [10:0] o_udp_len;

    modport master (
        output o_udp_data,
        output o_udp_de,
        input  i_udp_ready,
        output o_udp_sof,
        output o_udp_eof,
        output o_udp_frame_end,
        output o_udp_len
    );

    modport slave (
        input  o_udp_data,
        input  o_udp_de,
        output i_udp_ready,
        input  o_udp_sof,
        input  o_udp_eof,
        input  o_udp_frame_end,
        input  o_udp_len
    );
endinterface

// File: rtl/ddr3_master_rd.sv
// ddr3_master_rd
//   Reads one rank (256 x 64-bit) of the read dual-port buffer through port B
//   and unpacks it MSB-first into a valid/ready byte stream for the UDP
//   transmitter. Frees the rank with a one-cycle o_rd_done pulse once the
//   eof byte is accepted. One request may be held pending while busy; a
//   further request is dropped and sets the sticky o_rd_overflow flag.
//
//   Optional feature macro: DDR3_MASTER_RD_PKTCNT_EN
//     defined   : o_frame_pkt_cnt counts done pulses, cleared after the
//                 last packet of a frame
//     undefined : o_frame_pkt_cnt tied to 0
//
//   Ports:
//     i_pclk, i_rst_n        clock, asynchronous active-low reset
//     i_rd_req ...           request pulse with rank, 128-bit word count,
//                            last-word byte count and frame-end flag
//     o_dpb_rd_b_*           DPB port B (read only, address {rank, word})
//     i_dpb_rd_b_rd_data     DPB port B read data
//     udp                    byte stream (ddr3_master_rd_if.master)
//     o_rd_busy              packet in progress or pending
//     o_rd_done              rank released
//     o_rd_overflow          sticky: a request was dropped
//     o_frame_pkt_cnt        packet counter (see macro above)
module ddr3_master_rd #(
    parameter int unsigned DPB_RD_LATENCY         = 2,
    parameter logic [6:0]  UDP_FRAME_MAX_SIZE_128 = 7'd91
) (
    input  logic                   i_pclk,
    input  logic                   i_rst_n,
    input  logic                   i_rd_req,
    input  logic [1:0]             i_rd_buf_rank,
    input  logic [6:0]             i_rd_buf_128cnt,
    input  logic [5:0]             i_rd_buf_Bytecnt,
    input  logic                   i_rd_frame_down,
    input  logic [63:0]            i_dpb_rd_b_rd_data,
    output logic [9:0]             o_dpb_rd_b_addr,
    output logic                   o_dpb_rd_b_clk,
    output logic                   o_dpb_rd_b_cea,
    output logic                   o_dpb_rd_b_ocea,
    output logic                   o_dpb_rd_b_rst_n,
    output logic                   o_dpb_rd_b_wr_en,
    output logic [63:0]            o_dpb_rd_b_wr_data,
    ddr3_master_rd_if.master       udp,
    output logic                   o_rd_busy,
    output logic                   o_rd_done,
    output logic                   o_rd_overflow,
    output logic [7:0]             o_frame_pkt_cnt
);

    localparam logic [1:0] LAT_CYC = 2'(DPB_RD_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rank_q, rank_d;
    logic [10:0] len_q, len_d;
    logic        frame_q, frame_d;
    logic [7:0]  word_idx_q, word_idx_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [63:0] word_q, word_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic        pend_vld_q, pend_vld_d;
    logic [1:0]  pend_rank_q, pend_rank_d;
    logic [6:0]  pend_cnt_q, pend_cnt_d;
    logic [5:0]  pend_bytes_q, pend_bytes_d;
    logic        pend_frame_q, pend_frame_d;
    logic        ovf_q, ovf_d;

    // Launch source: the pending slot has priority over a new request.
    logic [1:0]  src_rank;
    logic [6:0]  src_cnt_raw;
    logic [6:0]  src_cnt;
    logic [6:0]  src_cnt_m1;
    logic [5:0]  src_bytes;
    logic        src_frame;
    logic [10:0] src_len;
    logic        can_launch;
    logic        launch;
    logic        is_shift;
    logic        last_byte;
    logic        hs;

    always_comb begin
        src_rank    = pend_vld_q ? pend_rank_q  : i_rd_buf_rank;
        src_cnt_raw = pend_vld_q ? pend_cnt_q   : i_rd_buf_128cnt;
        src_bytes   = pend_vld_q ? pend_bytes_q : i_rd_buf_Bytecnt;
        src_frame   = pend_vld_q ? pend_frame_q : i_rd_frame_down;
        src_cnt     = (src_cnt_raw > UDP_FRAME_MAX_SIZE_128) ? UDP_FRAME_MAX_SIZE_128 : src_cnt_raw;
        src_cnt_m1  = src_cnt - 7'd1;
        if (src_cnt == 7'd0) begin
            src_len = '0;
        end else if (src_bytes == 6'd0) begin
            src_len = {src_cnt, 4'b0000};
        end else begin
            src_len = {src_cnt_m1, 4'b0000} + {5'd0, src_bytes};
        end
    end

    assign is_shift   = (state_q == ST_SHIFT);
    assign last_byte  = (byte_cnt_q == len_q - 11'd1);
    assign hs         = is_shift && udp.i_udp_ready;
    // DONE also launches so a request arriving with the done pulse is
    // taken directly instead of competing for the single pending slot.
    assign can_launch = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign launch     = can_launch && (pend_vld_q || i_rd_req);

    always_comb begin
        state_d      = state_q;
        rank_d       = rank_q;
        len_d        = len_q;
        frame_d      = frame_q;
        word_idx_d   = word_idx_q;
        lat_cnt_d    = lat_cnt_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        byte_cnt_d   = byte_cnt_q;
        pend_vld_d   = pend_vld_q;
        pend_rank_d  = pend_rank_q;
        pend_cnt_d   = pend_cnt_q;
        pend_bytes_d = pend_bytes_q;
        pend_frame_d = pend_frame_q;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE: begin
            end
            ST_FETCH: begin
                // Address is held from FETCH entry; data is valid LAT_CYC
                // cycles after the memory first samples it.
                if (lat_cnt_q == LAT_CYC) begin
                    word_d     = i_dpb_rd_b_rd_data;
                    byte_idx_d = '0;
                    state_d    = ST_SHIFT;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_SHIFT: begin
                if (hs) begin
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    word_d     = {word_q[55:0], 8'h00};
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end else if (byte_idx_q == 3'd7) begin
                        word_idx_d = word_idx_q + 8'd1;
                        lat_cnt_d  = '0;
                        state_d    = ST_FETCH;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch) begin
            rank_d     = src_rank;
            len_d      = src_len;
            frame_d    = src_frame;
            word_idx_d = '0;
            lat_cnt_d  = '0;
            byte_idx_d = '0;
            byte_cnt_d = '0;
            state_d    = (src_cnt == 7'd0) ? ST_DONE : ST_FETCH;
            if (pend_vld_q) begin
                // Slot drains this cycle, so a concurrent request refills it.
                pend_vld_d   = i_rd_req;
                pend_rank_d  = i_rd_buf_rank;
                pend_cnt_d   = i_rd_buf_128cnt;
                pend_bytes_d = i_rd_buf_Bytecnt;
                pend_frame_d = i_rd_frame_down;
            end
        end else if (i_rd_req) begin
            if (!pend_vld_q) begin
                pend_vld_d   = 1'b1;
                pend_rank_d  = i_rd_buf_rank;
                pend_cnt_d   = i_rd_buf_128cnt;
                pend_bytes_d = i_rd_buf_Bytecnt;
                pend_frame_d = i_rd_frame_down;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            rank_q       <= '0;
            len_q        <= '0;
            frame_q      <= 1'b0;
            word_idx_q   <= '0;
            lat_cnt_q    <= '0;
            word_q       <= '0;
            byte_idx_q   <= '0;
            byte_cnt_q   <= '0;
            pend_vld_q   <= 1'b0;
            pend_rank_q  <= '0;
            pend_cnt_q   <= '0;
            pend_bytes_q <= '0;
            pend_frame_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rank_q       <= rank_d;
            len_q        <= len_d;
            frame_q      <= frame_d;
            word_idx_q   <= word_idx_d;
            lat_cnt_q    <= lat_cnt_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            pend_vld_q   <= pend_vld_d;
            pend_rank_q  <= pend_rank_d;
            pend_cnt_q   <= pend_cnt_d;
            pend_bytes_q <= pend_bytes_d;
            pend_frame_q <= pend_frame_d;
            ovf_q        <= ovf_d;
        end
    end

    assign o_dpb_rd_b_addr    = {rank_q, word_idx_q};
    assign o_dpb_rd_b_clk     = i_pclk;
    assign o_dpb_rd_b_cea     = 1'b1;
    assign o_dpb_rd_b_ocea    = 1'b1;
    assign o_dpb_rd_b_rst_n   = 1'b0;
    assign o_dpb_rd_b_wr_en   = 1'b0;
    assign o_dpb_rd_b_wr_data = '0;

    assign udp.o_udp_data      = word_q[63:56];
    assign udp.o_udp_de        = is_shift;
    assign udp.o_udp_sof       = is_shift && (byte_cnt_q == 11'd0);
    assign udp.o_udp_eof       = is_shift && last_byte;
    assign udp.o_udp_frame_end = is_shift && last_byte && frame_q;
    assign udp.o_udp_len       = len_q;

    assign o_rd_busy     = (state_q != ST_IDLE) || pend_vld_q;
    assign o_rd_done     = (state_q == ST_DONE);
    assign o_rd_overflow = ovf_q;

`ifdef DDR3_MASTER_RD_PKTCNT_EN
    logic [7:0] pkt_cnt_q, pkt_cnt_d;
    logic       pkt_clr_q, pkt_clr_d;

    // The final count of a frame stays visible for one cycle before clearing.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        pkt_clr_d = 1'b0;
        if (pkt_clr_q) begin
            pkt_cnt_d = '0;
        end
        if (state_q == ST_DONE) begin
            pkt_cnt_d = pkt_cnt_d + 8'd1;
            pkt_clr_d = frame_q;
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_cnt_q <= '0;
            pkt_clr_q <= 1'b0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            pkt_clr_q <= pkt_clr_d;
        end
    end

    assign o_frame_pkt_cnt = pkt_cnt_q;
`else
    assign o_frame_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr3_master_rd.sv
// tb_ddr3_master_rd
//   Table of packet requests applied in a loop, plus hand-written sequences
//   for queueing/overflow and mid-packet reset. Expected bytes come from a
//   memory model and are queued when a request is issued, then popped as the
//   DUT hands bytes over.
module tb_ddr3_master_rd;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic [1:0]  rd_rank;
    logic [6:0]  rd_cnt;
    logic [5:0]  rd_bytes;
    logic        rd_frame;
    logic [63:0] rd_data;
    logic [9:0]  addr;
    logic        b_clk, b_cea, b_ocea, b_rst_n, b_wr_en;
    logic [63:0] b_wr_data;
    logic        busy, done, ovf;
    logic [7:0]  pkt_cnt;

    ddr3_master_rd_if udp_if();

    ddr3_master_rd #(
        .DPB_RD_LATENCY(LAT),
        .UDP_FRAME_MAX_SIZE_128(7'd91)
    ) dut (
        .i_pclk(clk),
        .i_rst_n(rst_n),
        .i_rd_req(rd_req),
        .i_rd_buf_rank(rd_rank),
        .i_rd_buf_128cnt(rd_cnt),
        .i_rd_buf_Bytecnt(rd_bytes),
        .i_rd_frame_down(rd_frame),
        .i_dpb_rd_b_rd_data(rd_data),
        .o_dpb_rd_b_addr(addr),
        .o_dpb_rd_b_clk(b_clk),
        .o_dpb_rd_b_cea(b_cea),
        .o_dpb_rd_b_ocea(b_ocea),
        .o_dpb_rd_b_rst_n(b_rst_n),
        .o_dpb_rd_b_wr_en(b_wr_en),
        .o_dpb_rd_b_wr_data(b_wr_data),
        .udp(udp_if),
        .o_rd_busy(busy),
        .o_rd_done(done),
        .o_rd_overflow(ovf),
        .o_frame_pkt_cnt(pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DPB model: address sampled on the edge, data out LAT edges later.
    logic [63:0] mem [1024];
    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mem[addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[LAT-1];

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       fend;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [1:0] rank;
        logic [6:0] cnt;
        logic [5:0] bytes;
        logic       frame;
        logic       rnd;
        int         exp_len;
    } vec_t;
    vec_t vecs[8];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input logic [1:0] rank, input int len, input logic frame);
        logic [63:0] w;
        sb_t e;
        for (int i = 0; i < len; i++) begin
            w = mem[{rank, 8'(i / 8)}] << (8 * (i % 8));
            e.data = w[63:56];
            e.sof  = (i == 0);
            e.eof  = (i == len - 1);
            e.fend = (i == len - 1) && frame;
            sbq.push_back(e);
        end
    endtask

    task automatic drive_req(input logic [1:0] rank, input logic [6:0] cnt,
                             input logic [5:0] bytes, input logic frame);
        @(posedge clk);
        #1;
        rd_req   = 1'b1;
        rd_rank  = rank;
        rd_cnt   = cnt;
        rd_bytes = bytes;
        rd_frame = frame;
    endtask

    task automatic end_req();
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    // Waits for done_cnt to reach target; returns elapsed negedges.
    task automatic wait_done(input int target, input int limit, output int cycles);
        cycles = 0;
        while (done_cnt < target && cycles < limit) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk("done_reached", 64'(done_cnt), 64'(target));
    endtask

    // Ready driver
    initial begin
        udp_if.i_udp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            udp_if.i_udp_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: scoreboard pop, stall stability, done counting.
    initial begin
        logic       stalled;
        logic [9:0] held;
        sb_t        e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_de", 64'(udp_if.o_udp_de), 64'd1);
                    chk("stall_hold", 64'({udp_if.o_udp_data, udp_if.o_udp_sof, udp_if.o_udp_eof}), 64'(held));
                end
                if (done) done_cnt++;
                if (udp_if.o_udp_de && udp_if.i_udp_ready) begin
                    total++;
                    if (sbq.size() == 0) begin
                        bad++;
                        $display("FAIL extra_byte actual=%0h required=none", udp_if.o_udp_data);
                    end else begin
                        e = sbq.pop_front();
                        total--;
                        chk("byte", 64'({udp_if.o_udp_data, udp_if.o_udp_sof, udp_if.o_udp_eof, udp_if.o_udp_frame_end}),
                            64'({e.data, e.sof, e.eof, e.fend}));
                    end
                    stalled = 1'b0;
                end else if (udp_if.o_udp_de) begin
                    stalled = 1'b1;
                    held    = {udp_if.o_udp_data, udp_if.o_udp_sof, udp_if.o_udp_eof};
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        int cyc;
        int d0;
        for (int a = 0; a < 1024; a++) begin
            mem[a] = {16'(a), 16'(a) * 16'h3b + 16'h1, ~16'(a), 16'(a) ^ 16'h5a5a};
        end
        mem[0] = 64'h0102030405060708;

        //            rank cnt     bytes frame rnd  len
        vecs[0] = '{2'd1, 7'd2,   6'd0,  1'b0, 1'b0, 32};
        vecs[1] = '{2'd0, 7'd1,   6'd5,  1'b1, 1'b0, 5};
        vecs[2] = '{2'd2, 7'd0,   6'd0,  1'b0, 1'b0, 0};
        vecs[3] = '{2'd3, 7'd3,   6'd0,  1'b0, 1'b1, 48};
        vecs[4] = '{2'd0, 7'd2,   6'd15, 1'b1, 1'b1, 31};
        vecs[5] = '{2'd2, 7'd1,   6'd8,  1'b0, 1'b0, 8};
        vecs[6] = '{2'd1, 7'd127, 6'd0,  1'b0, 1'b0, 1456};
        vecs[7] = '{2'd3, 7'd91,  6'd1,  1'b1, 1'b1, 1441};

        rst_n = 1'b0;
        rd_req = 1'b0; rd_rank = '0; rd_cnt = '0; rd_bytes = '0; rd_frame = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_de", 64'(udp_if.o_udp_de), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_len", 64'(udp_if.o_udp_len), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            rnd_ready = vecs[v].rnd;
            push_pkt(vecs[v].rank, vecs[v].exp_len, vecs[v].frame);
            d0 = done_cnt;
            drive_req(vecs[v].rank, vecs[v].cnt, vecs[v].bytes, vecs[v].frame);
            end_req();
            wait_done(d0 + 1, 8000, cyc);
            if (vecs[v].cnt == 7'd0) chk("empty_latency_le3", 64'(cyc <= 3), 64'd1);
            repeat (3) @(negedge clk);
            #1;
            chk("one_done", 64'(done_cnt), 64'(d0 + 1));
            chk("len", 64'(udp_if.o_udp_len), 64'(vecs[v].exp_len));
            chk("sb_drained", 64'(sbq.size()), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            rnd_ready = 1'b0;
        end

        // Three back-to-back requests: first runs, second queued, third dropped.
        push_pkt(2'd1, 16, 1'b0);
        push_pkt(2'd2, 3, 1'b0);
        d0 = done_cnt;
        drive_req(2'd1, 7'd1, 6'd0, 1'b0);
        drive_req(2'd2, 7'd1, 6'd3, 1'b0);
        drive_req(2'd3, 7'd2, 6'd0, 1'b0);
        end_req();
        @(negedge clk);
        chk("b2b_ovf", 64'(ovf), 64'd1);
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(d0 + 2, 2000, cyc);
        repeat (5) @(negedge clk);
        #1;
        chk("b2b_dones", 64'(done_cnt), 64'(d0 + 2));
        chk("b2b_drained", 64'(sbq.size()), 64'd0);
        chk("b2b_len", 64'(udp_if.o_udp_len), 64'd3);
        chk("b2b_ovf_sticky", 64'(ovf), 64'd1);

        // Reset in the middle of a packet.
        push_pkt(2'd3, 32, 1'b1);
        drive_req(2'd3, 7'd2, 6'd0, 1'b1);
        end_req();
        cyc = 0;
        while (sbq.size() > 20 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_pkt_reached", 64'(sbq.size() <= 20), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_de", 64'(udp_if.o_udp_de), 64'd0);
        chk("arst_data", 64'({udp_if.o_udp_data, udp_if.o_udp_sof, udp_if.o_udp_eof, udp_if.o_udp_frame_end}), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        chk("arst_len", 64'(udp_if.o_udp_len), 64'd0);
        chk("arst_addr", 64'(addr), 64'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_pkt(2'd3, 16, 1'b0);
        d0 = done_cnt;
        drive_req(2'd3, 7'd1, 6'd0, 1'b0);
        end_req();
        wait_done(d0 + 1, 500, cyc);
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_drained", 64'(sbq.size()), 64'd0);
        chk("post_rst_len", 64'(udp_if.o_udp_len), 64'd16);
        chk("post_rst_ovf", 64'(ovf), 64'd0);
`ifndef DDR3_MASTER_RD_PKTCNT_EN
        chk("pkt_cnt_tied", 64'(pkt_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr3_master_rd.md
Name: ddr3_master_rd

Overview:
Read-side counterpart of the MJPEG-to-DDR3 write path. The DDR3 master fills one rank (256 x 64-bit) of the read dual-port buffer, then pulses a request carrying the rank, its 128-bit word count and the valid-byte count of the last word. This block reads that rank through DPB port B and unpacks it MSB-first into a valid/ready byte stream feeding the UDP transmitter. It frees the rank with a done pulse when the last byte has been sent.

Parameters:
DPB_RD_LATENCY, 2, cycles from o_dpb_rd_b_addr to valid i_dpb_rd_b_rd_data (ocea registered mode); legal values 1..3
UDP_FRAME_MAX_SIZE_128, 7'd91, maximum 128-bit words per packet; a larger request is clamped to this value

Ports:
i_pclk  in  1  clock; all logic is on the rising edge
i_rst_n  in  1  asynchronous active-low reset
i_rd_req  in  1  single-cycle request pulse; the rank is full
i_rd_buf_rank  in  2  rank to read (address bits [9:8])
i_rd_buf_128cnt  in  7  number of 128-bit words in the rank; 0 = empty packet
i_rd_buf_Bytecnt  in  6  valid bytes in the last 128-bit word; 0 = all 16 valid
i_rd_frame_down  in  1  this packet is the last one of its frame
i_dpb_rd_b_rd_data  in  64  DPB port B read data
o_dpb_rd_b_addr  out  10  {rank, word index}
o_dpb_rd_b_clk  out  1  = i_pclk
o_dpb_rd_b_cea / o_dpb_rd_b_ocea  out  1  constant 1
o_dpb_rd_b_rst_n  out  1  constant 0
o_dpb_rd_b_wr_en  out  1  constant 0
o_dpb_rd_b_wr_data  out  64  constant 0
o_udp_data  out  8  byte to transmit
o_udp_de  out  1  byte valid
i_udp_ready  in  1  sink accepts the byte when o_udp_de && i_udp_ready
o_udp_sof / o_udp_eof  out  1  first / last byte of the packet, qualified by o_udp_de
o_udp_frame_end  out  1  asserted with o_udp_eof on the last packet of a frame
o_udp_len  out  11  packet byte length, valid from the request until the next one
o_rd_busy  out  1  a packet is being read or is pending
o_rd_done  out  1  one-cycle pulse after the eof byte is accepted; the rank may be reused
o_rd_overflow  out  1  sticky flag: a request was dropped; cleared only by reset
o_frame_pkt_cnt  out  8  see Optional Feature

Behaviour:
- Reset: all outputs 0 (addr 0, len 0, busy 0); FSM goes to IDLE; the pending slot is cleared. A reset mid-packet aborts it without a done pulse.
- Length: len = Bytecnt==0 ? cnt*16 : (cnt-1)*16 + Bytecnt, computed in 11 bits. Last byte index = len-1.
- Byte order: even word address = bits [127:64] of the 128-bit word. Within each 64-bit word, [63:56] is sent first, down to [7:0].
- States:
  - IDLE: on a request (or a pending one), latch the parameters and go to FETCH. If cnt==0, skip FETCH and SHIFT and go to DONE.
  - FETCH: drive the address, wait DPB_RD_LATENCY cycles, capture the 64-bit word, go to SHIFT.
  - SHIFT: present bytes; advance on each handshake. After byte 7 of a word, or after the eof byte, increment the word index and go to FETCH, or to DONE after eof.
  - DONE: pulse o_rd_done for one cycle, then go to IDLE.
- Handshake: while o_udp_de=1, o_udp_data, sof and eof hold stable until i_udp_ready=1. o_udp_de is never deasserted without a transfer.
- Bytes past len in the last word are never presented.
- Queueing: one pending slot.
  - A request while busy is stored in the slot.
  - A request while the slot is full is dropped and sets o_rd_overflow.
  - A request in the same cycle as DONE is accepted normally.
- o_udp_frame_end tracks the latched i_rd_frame_down.

Optional Feature:
DDR3_MASTER_RD_PKTCNT_EN
- Defined: o_frame_pkt_cnt increments on each o_rd_done. When that done belongs to a frame_down packet, the counter instead loads 0 on the following cycle, after being visible as the final count for one cycle.
- Undefined: o_frame_pkt_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Request rank 1, cnt 2, Bytecnt 0, ready=1 -> addresses 0x100..0x103; 32 bytes out in DPB order; sof on byte 0; eof on byte 31; len=32; one o_rd_done.
- Request cnt 1, Bytecnt 5, frame_down=1, word 0x0102030405xxxxxx -> exactly bytes 01..05; eof and frame_end on 05; len=5.
- cnt 0 request -> no o_udp_de, o_rd_done within 3 cycles, len=0.
- Random ready toggling during a cnt 3 packet -> data stable while stalled; 48 bytes in order; no duplicates or gaps.
- Three back-to-back requests while busy -> second served after the first done; third dropped; o_rd_overflow=1 until reset.
- Assert i_rst_n=0 mid-SHIFT -> all outputs 0 asynchronously; a new request after release starts from word 0.
